nibble_serial_sub: RTL and testbench
====================================

// Module: nibble_serial_sub
//
// PURPOSE
//   Bit-serial WIDTH-bit subtractor: diff = a - b, computed LSB-first, one bit per clock.
//   Inverse arithmetic path to the registered nibble adder on the tile.
//   Sits between the ui_in operand nibbles and uo_out.
//   Start/busy/done handshake, so the tile top can sequence add and subtract results.
//
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>=2); bit counter is $clog2(WIDTH)+1 bits
//
// PORTS
//   clk      in   1      clock, all state on rising edge
//   rst_n    in   1      reset, asynchronous, active-low
//   start    in   1      request; sampled only in IDLE
//   a        in   WIDTH  minuend, captured on accepted start
//   b        in   WIDTH  subtrahend, captured on accepted start
//   busy     out  1      high while in BUSY or DONE
//   done     out  1      one-cycle pulse: diff/borrow valid
//   diff     out  WIDTH  result; held until next accepted start
//   borrow   out  1      final borrow-out (1 = a < b); held with diff
//
// BEHAVIOUR
//   Reset (rst_n=0, async):
//     state=IDLE; busy=0, done=0, diff=0, borrow=0; shift regs, counter, borrow_r cleared.
//     Applies immediately, including mid-operation; the in-flight op is discarded with no done.
//   FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE:
//     start=1 at edge E0: latch a->sa, b->sb, cnt=0, borrow_r=0; go BUSY.
//     start=0: stay; diff/borrow hold.
//   BUSY, edges E1..E_WIDTH, one bit each:
//     d      = sa[0] ^ sb[0] ^ borrow_r
//     br_nxt = (~sa[0] & sb[0]) | (~(sa[0]^sb[0]) & borrow_r)
//     Shift sa, sb right; shift d into result shift reg MSB; borrow_r <= br_nxt; cnt++.
//     At E_WIDTH (cnt==WIDTH-1): diff <= assembled result, borrow <= br_nxt, done <= 1; go DONE.
//   DONE: done=1 for exactly one cycle; at next edge done<=0, go IDLE.
//   Latency: done high in the cycle after E_WIDTH; next start accepted at E_WIDTH+2 at the earliest.
//     Throughput is one op per WIDTH+2 cycles.
//   start in BUSY/DONE: ignored, no queuing. start held high: back-to-back ops at max throughput.
//   a/b changes after E0: no effect on the current op.
//   Arithmetic: modulo 2^WIDTH. Wrap-around: 0-1 -> all ones, borrow=1.
//     a==b -> diff=0, borrow=0.
//   diff and borrow change only at the E_WIDTH edge; stable during BUSY.
//
// CONFIGURATION
//   SUB_SAT_EN defined:
//     At E_WIDTH, if final borrow=1 then diff <= 0 (unsigned saturation); borrow still reported as 1.
//   SUB_SAT_EN undefined:
//     diff is the raw modulo-2^WIDTH result.
//   Timing and handshake are identical in both builds.
//
// TESTING  (WIDTH=4)
//   1. Reset: rst_n=0 -> busy=0, done=0, diff=0, borrow=0; hold 3 cycles, outputs stay 0.
//   2. a=9, b=4, start 1 cycle:
//        busy high after E0; done=1 exactly one cycle after E4; diff=5, borrow=0;
//        diff/borrow hold after done falls.
//   3. a=3, b=5:
//        diff=0xE, borrow=1; with SUB_SAT_EN: diff=0x0, borrow=1.
//   4. Edge operands:
//        0-0 -> diff=0, borrow=0
//        F-F -> diff=0, borrow=0
//        0-1 -> diff=F, borrow=1 (SAT: 0)
//        F-0 -> diff=F, borrow=0
//   5. Handshake: start pulsed at E2, and a/b changed mid-op -> ignored, result from E0 operands.
//        start held high -> done every 6 cycles; each op uses the a/b present at its accept edge.
//   6. Reset mid-op: rst_n low between E2 and E3 -> busy=0, diff=0, no done pulse.
//        After release, a new start completes normally.

Source files
------------

// File: rtl/nibble_serial_sub_if.sv
// nibble_serial_sub_if: start/busy/done handshake and operand/result bus for the serial subtractor
interface nibble_serial_sub_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: LSB-first bit-serial a-b, one bit per clock, start/busy/done handshake.
// Define SUB_SAT_EN to clamp diff to zero whenever the final borrow is set.
module nibble_serial_sub #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst_n,
  nibble_serial_sub_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] sa, sb, res, diff_r;
  logic [CW-1:0]    cnt;
  logic             borrow_r, busy_r, done_r, borrow_o;
  logic             d, br_nxt;
  logic [WIDTH-1:0] full;
  assign d      = sa[0] ^ sb[0] ^ borrow_r;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow_r);
  // the bit computed on the final edge completes the result as its MSB
  assign full   = {d, res[WIDTH-1:1]};
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.diff   = diff_r;
  assign bus.borrow = borrow_o;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      cnt      <= '0;
      borrow_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      borrow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          sa       <= bus.a;
          sb       <= bus.b;
          cnt      <= '0;
          borrow_r <= 1'b0;
          busy_r   <= 1'b1;
          state    <= BUSY;
        end
        BUSY: begin
          sa       <= sa >> 1;
          sb       <= sb >> 1;
          res      <= full;
          borrow_r <= br_nxt;
          cnt      <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef SUB_SAT_EN
            diff_r <= br_nxt ? '0 : full;
`else
            diff_r <= full;
`endif
            borrow_o <= br_nxt;
            done_r   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb_nibble_serial_sub: directed vectors for the serial subtractor, expected values hand-computed.
module tb_nibble_serial_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  nibble_serial_sub_if #(.WIDTH(4)) bus ();
  nibble_serial_sub #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask
  function automatic logic [3:0] sat(input logic [3:0] raw, input logic br);
`ifdef SUB_SAT_EN
    return br ? 4'h0 : raw;
`else
    return raw;
`endif
  endfunction
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] rd, input logic rb, input bit disturb);
    int n;
    logic [3:0] prev;
    @(negedge clk);
    prev = bus.diff;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        chk({tag, "_hold_mid"}, 32'(bus.diff), 32'(prev));
        if (disturb) begin
          bus.start = 1'b1;
          bus.a = ~av;
          bus.b = av;
        end
      end
      if (i == 3) bus.start = 1'b0;
      if (bus.done) begin
        n = i;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'd5);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(sat(rd, rb)));
    chk({tag, "_borrow"}, 32'(bus.borrow), 32'(rb));
    @(negedge clk);
    chk({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    chk({tag, "_diff_hold"}, 32'(bus.diff), 32'(sat(rd, rb)));
    chk({tag, "_borrow_hold"}, 32'(bus.borrow), 32'(rb));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.start = 1'b0;
    bus.a = 4'h0;
    bus.b = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_diff", 32'(bus.diff), 32'd0);
      chk("rst_borrow", 32'(bus.borrow), 32'd0);
    end
    rst_n = 1'b1;
    run_op("9m4", 4'h9, 4'h4, 4'h5, 1'b0, 1'b0);
    run_op("3m5", 4'h3, 4'h5, 4'hE, 1'b1, 1'b0);
    run_op("0m0", 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    run_op("6m6", 4'h6, 4'h6, 4'h0, 1'b0, 1'b0);
    run_op("FmF", 4'hF, 4'hF, 4'h0, 1'b0, 1'b0);
    run_op("0m1", 4'h0, 4'h1, 4'hF, 1'b1, 1'b0);
    run_op("Fm0", 4'hF, 4'h0, 4'hF, 1'b0, 1'b0);
    run_op("Am3_dist", 4'hA, 4'h3, 4'h7, 1'b0, 1'b1);
    // start held high: operands for the second op are presented right after the first accept
    @(negedge clk);
    bus.a = 4'h7;
    bus.b = 4'h2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 4'h2;
    bus.b = 4'h7;
    wait_done(n);
    chk("held1_latency", 32'(n), 32'd5);
    chk("held1_diff", 32'(bus.diff), 32'h5);
    chk("held1_borrow", 32'(bus.borrow), 32'd0);
    wait_done(n);
    chk("held2_period", 32'(n), 32'd6);
    chk("held2_diff", 32'(bus.diff), 32'(sat(4'hB, 1'b1)));
    chk("held2_borrow", 32'(bus.borrow), 32'd1);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_idle_busy", 32'(bus.busy), 32'd0);
    run_op("Cm7", 4'hC, 4'h7, 4'h5, 1'b0, 1'b0);
    // reset lands between E2 and E3 of an in-flight op
    @(negedge clk);
    bus.a = 4'h1;
    bus.b = 4'h4;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_diff", 32'(bus.diff), 32'd0);
    chk("mid_rst_borrow", 32'(bus.borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    chk("mid_rst_no_done", 32'(n), 32'd0);
    run_op("after_rst", 4'hC, 4'h3, 4'h9, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
